// File: rtl/rsa_modexp_core_if.sv
// Operand/result bundle for the modular-exponentiation engine.
// The master drives operands and the slave (the core) returns the result.
interface rsa_modexp_core_if #(
    parameter int WIDTH = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH*2-1:0]   in_text;
    logic [WIDTH*2-1:0]   in_key;
    logic [WIDTH*2-1:0]   in_n;
    logic                 out_valid;
    logic [WIDTH*2-1:0]   out_text;
    logic                 out_err;

    modport master (
        output in_valid, in_text, in_key, in_n,
        input  in_ready, out_valid, out_text, out_err
    );

    modport slave (
        input  in_valid, in_text, in_key, in_n,
        output in_ready, out_valid, out_text, out_err
    );
endinterface

// File: rtl/rsa_modexp_core.sv
// LSB-first square-and-multiply engine: out_text = in_text^in_key mod in_n.
// One operation in flight; WIDTH*2 exponent steps per operation.
module rsa_modexp_core #(
    parameter int WIDTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    rsa_modexp_core_if.slave  bus,
    output logic [1:0]        o_state
);
    localparam int W2 = WIDTH * 2;
    localparam int W4 = WIDTH * 4;
    localparam int CW = $clog2(W2);
    localparam logic [CW-1:0] CNT_LAST = CW'(W2 - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [W2-1:0] r_mod;
    logic [W2-1:0] r_base;
    logic [W2-1:0] r_exp;
    logic [W2-1:0] r_res;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic [W2-1:0] r_out_text;
    logic          r_out_err;

    logic          w_cap_err;
    logic [W2-1:0] w_cap_mod;
    logic [W2-1:0] w_cap_base;
    logic [W2-1:0] w_mod_safe;
    logic [W4-1:0] w_mod_ext;
    logic [W4-1:0] w_prod_rb;
    logic [W4-1:0] w_prod_bb;
    logic [W2-1:0] w_res_next;
    logic [W2-1:0] w_base_next;

    // A zero modulus is replaced by 1 for the divider so % never sees zero;
    // the err flag then forces base/res to 0 so the substitute never shows.
    always_comb begin
        w_cap_err   = (bus.in_n == '0);
        w_cap_mod   = w_cap_err ? W2'(1) : bus.in_n;
        w_cap_base  = bus.in_text % w_cap_mod;
        w_mod_safe  = r_err ? W2'(1) : r_mod;
        w_mod_ext   = {{W2{1'b0}}, w_mod_safe};
        w_prod_rb   = {{W2{1'b0}}, r_res}  * {{W2{1'b0}}, r_base};
        w_prod_bb   = {{W2{1'b0}}, r_base} * {{W2{1'b0}}, r_base};
        w_res_next  = r_res;
        w_base_next = W2'(w_prod_bb % w_mod_ext);
        if (r_exp[0]) begin
            w_res_next = W2'(w_prod_rb % w_mod_ext);
        end
        if (r_err) begin
            w_res_next  = '0;
            w_base_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mod      <= '0;
            r_base     <= '0;
            r_exp      <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_out_text <= '0;
            r_out_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_mod   <= bus.in_n;
                        r_base  <= w_cap_err ? '0 : w_cap_base;
                        r_exp   <= bus.in_key;
                        r_res   <= (bus.in_n <= W2'(1)) ? '0 : W2'(1);
                        r_cnt   <= '0;
                        r_err   <= w_cap_err;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_res  <= w_res_next;
                    r_base <= w_base_next;
                    r_exp  <= r_exp >> 1;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_out_text <= w_res_next;
                        r_out_err  <= r_err;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake: operands are taken on an edge where in_valid && in_ready;
    // in_ready is high only in IDLE, out_valid only in DONE, so they never overlap.
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_text  = r_out_text;
    assign bus.out_err   = r_out_err;
    assign o_state       = r_state;
endmodule
